// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide execution unit placed after the operand shifter.
// Computes one radix-2 step per clock: shift-add for multiply, restoring
// shift-subtract for divide. Signed operations run on magnitudes and the
// signs are fixed up in a single cycle before the result is published.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request pulse, only looked at while idle
//   op      00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//   ain     operand A: multiplicand / dividend
//   bin     operand B (shifter output): multiplier / divisor
//   busy    high from the cycle after acceptance until done
//   done    one-cycle pulse, results valid
//   res_lo  product low half / quotient
//   res_hi  product high half / remainder
//   flags   {V,N,Z} of the published result
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one radix-2 step per cycle, WIDTH cycles
// FIX   | sign correction and exception override, results registered
// DONE  | last busy cycle; done is raised on the following cycle
// ----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [2:0]       flags
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // acc holds {product_hi, product_lo} for multiply and {remainder, quotient}
  // for divide; the low half starts as the multiplier / dividend magnitude.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw;     // original dividend, returned on divide by zero
  logic [1:0]         op_q;
  logic               neg_q;     // product / quotient is negative
  logic               neg_r;     // remainder is negative (dividend sign)
  logic               div0;
  logic               ovf;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic               busy_nxt;
  logic               done_nxt;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   fix_lo, fix_hi;
  logic               fix_v;

  assign accept = (state == IDLE) && start;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. busy/done are registered; done follows the DONE state by
  // one cycle, so when it is seen the unit is already idle and a start in that
  // same cycle is taken on the next edge.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Operand conditioning at acceptance
  // --------------------------------------------------------------------------
  always_comb begin
    a_neg = op[0] & ain[WIDTH-1];
    b_neg = op[0] & bin[WIDTH-1];
    a_mag = a_neg ? (~ain + 1'b1) : ain;
    b_mag = b_neg ? (~bin + 1'b1) : bin;
  end

  // --------------------------------------------------------------------------
  // Radix-2 step
  // --------------------------------------------------------------------------
  always_comb begin
    // Multiply: conditionally add multiplicand into the upper half, then shift
    // the whole {carry, hi, lo} right by one.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: the shifted partial remainder is WIDTH+1 bits wide; when it is
    // not below the divisor the difference always fits back into WIDTH bits.
    div_ge   = ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} >= {1'b0, mcand});
    div_diff = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]} - mcand;
    div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                      : {acc[2*WIDTH-2:0], 1'b0};
  end

  // --------------------------------------------------------------------------
  // Sign correction, exceptions and overflow flag
  // --------------------------------------------------------------------------
  always_comb begin
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    quo_fix  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    fix_lo   = '0;
    fix_hi   = '0;
    fix_v    = 1'b0;
    if (!op_q[1]) begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      if (op_q[0]) fix_v = (fix_hi != {WIDTH{fix_lo[WIDTH-1]}});
      else         fix_v = (fix_hi != '0);
    end else if (div0) begin
      fix_lo = '1;
      fix_hi = a_raw;
      fix_v  = 1'b1;
    end else begin
      // The most-negative / -1 case already yields quotient = dividend and
      // remainder = 0 through the magnitude path; only V needs raising.
      fix_lo = quo_fix;
      fix_hi = rem_fix;
      fix_v  = ovf;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      a_raw  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
      res_lo <= '0;
      res_hi <= '0;
      flags  <= '0;
    end else begin
      if (accept) begin
        op_q  <= op;
        a_raw <= ain;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        div0  <= op[1] & (bin == '0);
        ovf   <= (op == 2'b11) && (ain == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (bin == '1);
        cnt   <= '0;
        if (op[1]) begin
          acc   <= {{WIDTH{1'b0}}, a_mag};
          mcand <= b_mag;
        end else begin
          acc   <= {{WIDTH{1'b0}}, b_mag};
          mcand <= a_mag;
        end
      end else if (state == RUN) begin
        acc <= op_q[1] ? div_next : mul_next;
        cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
        res_lo <= fix_lo;
        res_hi <= fix_hi;
        flags  <= {fix_v, fix_lo[WIDTH-1], (fix_lo == '0)};
      end
    end
  end

endmodule
